dmem_bus_bridge: RTL and testbench



---
 rtl/dmem_pkg.sv | 14 +
 rtl/dmem_bus_bridge_if.sv | 26 ++
 rtl/dmem_bus_bridge.sv | 118 +++++++++++
 tb/tb_dmem_bus_bridge.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory bus bridge.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2,
    DONE     = 2'd3
  } dmem_state_t;

  localparam logic [3:0] BE_ALL             = 4'b1111;
  localparam int         TIMEOUT_CYCLES_DEF = 255;

endpackage

// File: rtl/dmem_bus_bridge_if.sv
// Valid/ready data-memory bus between the bridge (master) and the memory (slave).
interface dmem_bus_bridge_if #(
  parameter int ADDR_W = 32
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [3:0]        req_be;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_bus_bridge.sv
// Turns each core load/store into one bus transaction and stalls the core until it completes.
// Optional bus wait limit enabled by defining DMEM_TIMEOUT_EN.
module dmem_bus_bridge
  import dmem_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [31:0]         wordW,
  input  logic [3:0]          be,
  input  logic                not_align,
  output logic [31:0]         rword,
  output logic                stall,
  output logic                access_fault,
  dmem_bus_bridge_if.master   bus
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_REQ  = REQ;
  localparam logic [1:0] ST_WAIT = WAIT_RSP;
  localparam logic [1:0] ST_DONE = DONE;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic              pending;
  logic              expire;
  logic              req_we_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic [31:0]       req_wdata_q;
  logic [3:0]        req_be_q;

  assign pending = (mem_read | mem_write) & ~not_align;

`ifdef DMEM_TIMEOUT_EN
  // Counter is cleared while idle so it starts from zero on entry to REQ; it saturates to avoid wrapping.
  logic [7:0] wait_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (state == ST_IDLE) begin
      wait_cnt <= '0;
    end else if ((state == ST_REQ || state == ST_WAIT) && wait_cnt != 8'hFF) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  assign expire = (state == ST_REQ || state == ST_WAIT) && (wait_cnt >= TIMEOUT_CYCLES[7:0]);
`else
  assign expire = 1'b0;
`endif

  // A handshake or response in the expiry cycle takes priority over the timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (pending) state_nxt = ST_REQ;
      ST_REQ: begin
        if (bus.req_ready)  state_nxt = ST_WAIT;
        else if (expire)    state_nxt = ST_DONE;
      end
      ST_WAIT: if (bus.rsp_valid || expire) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      rword        <= '0;
      access_fault <= 1'b0;
      req_we_q     <= 1'b0;
      req_addr_q   <= '0;
      req_wdata_q  <= '0;
      req_be_q     <= '0;
    end else begin
      state        <= state_nxt;
      access_fault <= 1'b0;
      if (state == ST_IDLE && pending) begin
        req_we_q    <= mem_write;
        req_addr_q  <= addr & ~ADDR_W'(3);
        req_wdata_q <= wordW;
        req_be_q    <= mem_write ? be : BE_ALL;
      end
      // Stores leave rword untouched unless the access faults.
      if (state == ST_WAIT && bus.rsp_valid) begin
        if (bus.rsp_err) begin
          rword        <= '0;
          access_fault <= 1'b1;
        end else if (!req_we_q) begin
          rword <= bus.rsp_rdata;
        end
      end else if (expire && state_nxt == ST_DONE) begin
        rword        <= '0;
        access_fault <= 1'b1;
      end
    end
  end

  assign bus.req_valid = (state == ST_REQ);
  assign bus.req_we    = req_we_q;
  assign bus.req_addr  = req_addr_q;
  assign bus.req_wdata = req_wdata_q;
  assign bus.req_be    = req_be_q;

  assign stall = ((state == ST_IDLE) && pending) || (state == ST_REQ) || (state == ST_WAIT);

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Self-checking bench for dmem_bus_bridge: directed vector table, reset/timeout sequences, random transactions.
module tb_dmem_bus_bridge;

  localparam int ADDR_W = 32;
  localparam int TO     = 4;
`ifdef DMEM_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct {
    logic        rd, wr, na;
    logic [31:0] a, w;
    logic [3:0]  b;
    int          d, r;
    logic        err, noise;
    logic [31:0] rdata;
  } txn_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    int          stall, req_cyc;
    logic [31:0] rword;
    logic        fault;
  } exp_t;

  typedef struct {
    txn_t t;
    exp_t e;
  } vec_t;

  typedef struct {
    int          stall, req_cyc, field_bad, fault_other, early, hung;
    logic [31:0] rword_done, rword_post;
    logic        fault_done;
  } obs_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              mem_read = 1'b0, mem_write = 1'b0, not_align = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [31:0]       wordW = '0;
  logic [3:0]        be = '0;
  logic [31:0]       rword;
  logic              stall, access_fault;

  int errors = 0;
  int checks = 0;
  logic [31:0] model_rword;

  dmem_bus_bridge_if #(.ADDR_W(ADDR_W)) bus ();

  dmem_bus_bridge #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wordW(wordW), .be(be), .not_align(not_align),
    .rword(rword), .stall(stall), .access_fault(access_fault), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Transaction-level reference: cycle counts from handshake/response delays, result word from the access kind.
  function automatic exp_t model(input txn_t t, input logic [31:0] prev);
    exp_t e;
    int   wait_cyc, j0;
    bit   tmo;
    e.we = t.wr;  e.addr = t.a & 32'hFFFF_FFFC;  e.be = t.wr ? t.b : 4'hF;
    e.stall = 0;  e.req_cyc = 0;  e.rword = prev;  e.fault = 1'b0;
    if (!((t.rd | t.wr) && !t.na)) return e;
    tmo = 1'b0;  e.req_cyc = t.d + 1;  wait_cyc = t.r + 1;
    if (TO_EN) begin
      if (t.d > TO) begin
        tmo = 1'b1;  e.req_cyc = TO + 1;  wait_cyc = 0;
      end else begin
        j0 = (TO - t.d - 1 > 0) ? TO - t.d - 1 : 0;
        if (j0 < t.r) begin tmo = 1'b1;  wait_cyc = j0 + 1; end
      end
    end
    e.stall = 1 + e.req_cyc + wait_cyc;
    if (tmo || t.err) begin e.rword = '0;  e.fault = 1'b1; end
    else if (!t.wr)   e.rword = t.rdata;
    return e;
  endfunction

  // Starts just after a rising edge with the bridge idle; plays core and memory roles until DONE.
  task automatic apply_stimulus(input txn_t t, input exp_t e, output obs_t o);
    int   cyc, rdy_wait, rsp_wait;
    bit   in_rsp, fin, pend;
    logic [31:0] last;
    o = '{default: 0};
    pend = (t.rd | t.wr) && !t.na;
    mem_read = t.rd;  mem_write = t.wr;  not_align = t.na;
    addr = t.a;  wordW = t.w;  be = t.b;
    cyc = 0;  rdy_wait = 0;  rsp_wait = 0;  in_rsp = 1'b0;  fin = 1'b0;  last = rword;
    while (!fin) begin
      bus.req_ready = bus.req_valid && (rdy_wait >= t.d);
      bus.rsp_valid = in_rsp ? (rsp_wait >= t.r) : (t.noise && bus.req_valid);
      bus.rsp_err   = bus.rsp_valid && (in_rsp ? t.err : 1'b1);
      bus.rsp_rdata = bus.rsp_valid && in_rsp ? t.rdata : $urandom;
      @(negedge clk);
      if (stall) o.stall++;
      if (bus.req_valid) begin
        o.req_cyc++;
        if (bus.req_addr !== e.addr || bus.req_we !== e.we || bus.req_be !== e.be ||
            (e.we && bus.req_wdata !== t.w)) o.field_bad++;
      end
      if (pend && !stall && cyc > 0) begin
        o.rword_done = rword;  o.fault_done = access_fault;  fin = 1'b1;
      end else begin
        if (access_fault) o.fault_other++;
        if (rword !== last) o.early++;
      end
      if (!pend && cyc >= 2) begin o.rword_done = rword;  fin = 1'b1; end
      if (cyc >= 400) begin o.hung = 1;  fin = 1'b1; end
      if (bus.req_valid && bus.req_ready) in_rsp = 1'b1;
      else if (bus.req_valid)             rdy_wait++;
      else if (in_rsp) begin
        if (bus.rsp_valid) in_rsp = 1'b0;
        else               rsp_wait++;
      end
      cyc++;
      @(posedge clk); #1;
    end
    mem_read = 1'b0;  mem_write = 1'b0;  not_align = 1'b0;
    bus.req_ready = 1'b0;  bus.rsp_valid = 1'b0;  bus.rsp_err = 1'b0;
    @(negedge clk);
    o.rword_post = rword;
    if (access_fault) o.fault_other++;
    @(posedge clk); #1;
  endtask

  task automatic verify(input string tag, input obs_t o, input exp_t e);
    check_output({tag, " hang"},        o.hung,        0);
    check_output({tag, " stall"},       o.stall,       e.stall);
    check_output({tag, " req_cycles"},  o.req_cyc,     e.req_cyc);
    check_output({tag, " req_fields"},  o.field_bad,   0);
    check_output({tag, " rword_done"},  o.rword_done,  e.rword);
    check_output({tag, " rword_post"},  o.rword_post,  e.rword);
    check_output({tag, " rword_early"}, o.early,       0);
    check_output({tag, " fault_done"},  32'(o.fault_done), 32'(e.fault));
    check_output({tag, " fault_other"}, o.fault_other, 0);
  endtask

  function automatic vec_t mk(input logic rd, wr, na, input logic [31:0] a, w, input logic [3:0] b,
                              input int d, r, input logic err, noise, input logic [31:0] rdata,
                              input logic [31:0] ea, input logic ewe, input logic [3:0] ebe,
                              input int est, erq, input logic [31:0] erw, input logic ef);
    vec_t v;
    v.t = '{rd: rd, wr: wr, na: na, a: a, w: w, b: b, d: d, r: r, err: err, noise: noise, rdata: rdata};
    v.e = '{addr: ea, we: ewe, be: ebe, stall: est, req_cyc: erq, rword: erw, fault: ef};
    return v;
  endfunction

  initial begin
    vec_t vecs[$];
    obs_t o;
    txn_t t;
    exp_t e;

    bus.req_ready = 1'b0;  bus.rsp_valid = 1'b0;  bus.rsp_err = 1'b0;  bus.rsp_rdata = '0;
    #12;
    check_output("reset rword",     rword,          0);
    check_output("reset req_addr",  bus.req_addr,   0);
    check_output("reset req_wdata", bus.req_wdata,  0);
    check_output("reset req_be",    32'(bus.req_be), 0);
    check_output("reset req_valid", 32'(bus.req_valid), 0);
    check_output("reset req_we",    32'(bus.req_we), 0);
    check_output("reset fault",     32'(access_fault), 0);
    check_output("reset stall",     32'(stall), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    vecs.push_back(mk(1,0,0, 32'h10, 32'h0, 4'h0, 0,0, 0,0, 32'hDEADBEEF, 32'h10, 0, 4'hF, 3,1, 32'hDEADBEEF, 0));
    vecs.push_back(mk(0,1,0, 32'h13, 32'hA5A5A5A5, 4'h8, 2,0, 0,0, 32'h55, 32'h10, 1, 4'h8, 5,3, 32'hDEADBEEF, 0));
    vecs.push_back(mk(1,0,1, 32'h10, 32'h0, 4'h0, 0,0, 0,0, 32'h0, 32'h10, 0, 4'hF, 0,0, 32'hDEADBEEF, 0));
    vecs.push_back(mk(1,0,0, 32'h20, 32'h0, 4'h0, 0,1, 1,0, 32'h12345678, 32'h20, 0, 4'hF, 4,1, 32'h0, 1));
    vecs.push_back(mk(1,0,0, 32'h7, 32'h0, 4'h0, 1,1, 0,0, 32'hCAFEF00D, 32'h4, 0, 4'hF, 5,2, 32'hCAFEF00D, 0));
    vecs.push_back(mk(1,1,0, 32'hFFFFFFFE, 32'h11223344, 4'h3, 0,0, 0,0, 32'h9, 32'hFFFFFFFC, 1, 4'h3, 3,1, 32'hCAFEF00D, 0));
    vecs.push_back(mk(0,1,0, 32'h100, 32'h0, 4'hF, 0,2, 1,0, 32'h0, 32'h100, 1, 4'hF, 5,1, 32'h0, 1));
    vecs.push_back(mk(1,0,0, 32'h40, 32'h0, 4'h0, 1,0, 0,1, 32'h0BADC0DE, 32'h40, 0, 4'hF, 4,2, 32'h0BADC0DE, 0));
    vecs.push_back(mk(0,0,0, 32'h80, 32'h0, 4'h0, 0,0, 0,0, 32'h0, 32'h80, 0, 4'hF, 0,0, 32'h0BADC0DE, 0));

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].t, vecs[i].e, o);
      verify($sformatf("vec%0d", i), o, vecs[i].e);
    end
    model_rword = 32'h0BADC0DE;

    // Reset while a load waits for its response.
    mem_read = 1'b1;  addr = 32'h30;
    @(posedge clk); #1;
    check_output("rst_seq req_valid in REQ", 32'(bus.req_valid), 1);
    bus.req_ready = 1'b1;
    @(posedge clk); #1;
    bus.req_ready = 1'b0;
    check_output("rst_seq stall in WAIT", 32'(stall), 1);
    @(negedge clk);
    rst_n = 1'b0;  mem_read = 1'b0;
    #1;
    check_output("rst_seq req_valid", 32'(bus.req_valid), 0);
    check_output("rst_seq stall",     32'(stall), 0);
    check_output("rst_seq rword",     rword, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    model_rword = '0;
    t = '{rd: 1, wr: 0, na: 0, a: 32'h34, w: 0, b: 0, d: 0, r: 0, err: 0, noise: 0, rdata: 32'h600DF00D};
    e = model(t, model_rword);
    apply_stimulus(t, e, o);
    verify("post_reset lw", o, e);
    model_rword = e.rword;

    if (TO_EN) begin
      t = '{rd: 1, wr: 0, na: 0, a: 32'h50, w: 0, b: 0, d: 0, r: 1000, err: 0, noise: 0, rdata: 32'h1};
      e = model(t, model_rword);
      apply_stimulus(t, e, o);
      verify("timeout", o, e);
      check_output("timeout wait cycles", o.stall - 1 - o.req_cyc, 4);
      check_output("timeout fault", 32'(o.fault_done), 1);
      model_rword = e.rword;
    end

    for (int i = 0; i < 40; i++) begin
      int kind;
      kind  = $urandom_range(0, 9);
      t.a   = $urandom;  t.w = $urandom;  t.rdata = $urandom;
      t.b   = 4'($urandom_range(1, 15));
      t.d   = $urandom_range(0, 3);  t.r = $urandom_range(0, 3);
      t.err = ($urandom_range(0, 7) == 0);
      t.noise = 1'($urandom_range(0, 1));
      t.na  = (kind == 1);
      t.rd  = (kind == 0) ? 1'b0 : (kind == 1 ? 1'b1 : 1'($urandom_range(0, 1)));
      t.wr  = (kind == 0) ? 1'b0 : (kind == 1 ? 1'b0 : (t.rd ? 1'($urandom_range(0, 1)) : 1'b1));
      e = model(t, model_rword);
      apply_stimulus(t, e, o);
      verify($sformatf("rnd%0d", i), o, e);
      model_rword = e.rword;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
